// File: rtl/ddr_tx_sequencer.sv
// DDR transmit lane sequencer: serializes stream words two bits per clock onto a data ODDR,
// drives a forwarded-clock ODDR, and owns ODDR reset/CE bring-up after power-up.
module ddr_tx_sequencer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned RST_CYCLES = 4,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             dq_d1,
    output logic             dq_d2,
    output logic             fclk_d1,
    output logic             fclk_d2,
    output logic             oddr_ce,
    output logic             oddr_r,
    output logic             busy,
    output logic             word_done
);

    localparam int unsigned Beats = WIDTH / 2;
    localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int unsigned CntW  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);
    localparam logic [CntW-1:0]  RstLast  = CntW'(RST_CYCLES - 1);
    localparam logic             OneBeat  = (Beats == 1);

    typedef enum logic [1:0] {StRst, StIdle, StShift} state_e;

    state_e           state_q;
    logic [CntW-1:0]  rst_cnt_q;
    logic [BeatW-1:0] beat_q;
    logic [WIDTH-1:0] word_q;

    logic [BeatW-1:0] beat_inc;
    logic [WIDTH-1:0] word_nxt;
    logic             accept;
    logic             at_last;

    always_comb begin
        beat_inc = beat_q + 1'b1;
        word_nxt = word_q >> 2;
        accept   = s_valid & s_ready;
        at_last  = (beat_q == LastBeat);
    end

    // word_q holds the not-yet-sent bits right-aligned, so bits [1:0] are always the current pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRst;
            rst_cnt_q <= '0;
            beat_q    <= '0;
            word_q    <= '0;
            s_ready   <= 1'b0;
            dq_d1     <= IDLE_LEVEL;
            dq_d2     <= IDLE_LEVEL;
            fclk_d1   <= 1'b0;
            fclk_d2   <= 1'b0;
            oddr_ce   <= 1'b0;
            oddr_r    <= 1'b1;
            busy      <= 1'b0;
            word_done <= 1'b0;
        end else begin
            unique case (state_q)
                StRst: begin
                    if (rst_cnt_q == RstLast) begin
                        state_q <= StIdle;
                        oddr_r  <= 1'b0;
                        oddr_ce <= 1'b1;
                        s_ready <= enable;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                StIdle, StShift: begin
                    if (accept) begin
                        state_q   <= StShift;
                        word_q    <= s_data;
                        beat_q    <= '0;
                        dq_d1     <= s_data[0];
                        dq_d2     <= s_data[1];
                        fclk_d1   <= 1'b1;
                        fclk_d2   <= 1'b0;
                        busy      <= 1'b1;
                        word_done <= OneBeat;
                        s_ready   <= OneBeat & enable;
                    end else if (state_q == StShift && !at_last) begin
                        beat_q    <= beat_inc;
                        word_q    <= word_nxt;
                        dq_d1     <= word_nxt[0];
                        dq_d2     <= word_nxt[1];
                        word_done <= (beat_inc == LastBeat);
                        s_ready   <= (beat_inc == LastBeat) & enable;
                    end else begin
                        // Idle, or last beat shown with no follow-on word: park the lane.
                        state_q   <= StIdle;
                        dq_d1     <= IDLE_LEVEL;
                        dq_d2     <= IDLE_LEVEL;
                        fclk_d1   <= 1'b0;
                        fclk_d2   <= 1'b0;
                        busy      <= 1'b0;
                        word_done <= 1'b0;
                        s_ready   <= enable;
                    end
                end
                default: state_q <= StRst;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_tx_sequencer.sv
// Bench for ddr_tx_sequencer: a beats-remaining model checked every cycle on an 8-bit lane,
// plus literal expectations on that lane and on a 2-bit, idle-high lane.
module tb_ddr_tx_sequencer;

    localparam int unsigned W_A    = 8;
    localparam int unsigned RST_A  = 4;
    localparam logic        IDLE_A = 1'b0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b1;
    logic s_valid = 1'b0;
    logic [W_A-1:0] s_data = '0;
    logic s_ready, dq_d1, dq_d2, fclk_d1, fclk_d2, oddr_ce, oddr_r, busy, word_done;

    logic s_valid_b = 1'b0;
    logic [1:0] s_data_b = '0;
    logic s_ready_b, dq_d1_b, dq_d2_b, fclk_d1_b, fclk_d2_b, oddr_ce_b, oddr_r_b, busy_b;
    logic word_done_b;

    int n_checks = 0;
    int n_errs = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    ddr_tx_sequencer #(.WIDTH(W_A), .RST_CYCLES(RST_A), .IDLE_LEVEL(IDLE_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .dq_d1(dq_d1), .dq_d2(dq_d2), .fclk_d1(fclk_d1), .fclk_d2(fclk_d2),
        .oddr_ce(oddr_ce), .oddr_r(oddr_r), .busy(busy), .word_done(word_done)
    );

    ddr_tx_sequencer #(.WIDTH(2), .RST_CYCLES(2), .IDLE_LEVEL(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(1'b1), .s_valid(s_valid_b), .s_ready(s_ready_b),
        .s_data(s_data_b), .dq_d1(dq_d1_b), .dq_d2(dq_d2_b), .fclk_d1(fclk_d1_b),
        .fclk_d2(fclk_d2_b), .oddr_ce(oddr_ce_b), .oddr_r(oddr_r_b), .busy(busy_b),
        .word_done(word_done_b)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: the lane shows one pair per cycle while beats remain; s_ready only on the last one.
    typedef struct packed {
        logic       in_rst;
        logic [7:0] edges;
        logic [7:0] left;
        logic [7:0] word;
        logic ready, d1, d2, f1, f2, ce, r, bsy, done;
    } model_t;

    function automatic model_t model_reset();
        model_t n;
        n = '0;
        n.in_rst = 1'b1;
        n.d1 = IDLE_A;
        n.d2 = IDLE_A;
        n.r = 1'b1;
        return n;
    endfunction

    function automatic model_t model_next(model_t m, logic en, logic v, logic [7:0] d);
        model_t n;
        n = m;
        if (m.in_rst) begin
            n.edges = m.edges + 8'd1;
            if (n.edges == 8'(RST_A)) begin
                n.in_rst = 1'b0;
                n.r = 1'b0;
                n.ce = 1'b1;
                n.ready = en;
            end
        end else begin
            if (v && m.ready) begin
                n.word = d;
                n.left = 8'(W_A / 2);
            end else if (m.left != 0) begin
                n.left = m.left - 8'd1;
                n.word = m.word >> 2;
            end
            if (n.left != 0) begin
                n.d1 = n.word[0];
                n.d2 = n.word[1];
                n.f1 = 1'b1;
                n.bsy = 1'b1;
                n.done = (n.left == 8'd1);
                n.ready = (n.left == 8'd1) && en;
            end else begin
                n.d1 = IDLE_A;
                n.d2 = IDLE_A;
                n.f1 = 1'b0;
                n.bsy = 1'b0;
                n.done = 1'b0;
                n.ready = en;
            end
            n.f2 = 1'b0;
        end
        return n;
    endfunction

    model_t m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_next(m, enable, s_valid, s_data);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cycle", {7'd0, s_ready, dq_d1, dq_d2, fclk_d1, fclk_d2, oddr_ce, oddr_r, busy,
                          word_done},
                {7'd0, m.ready, m.d1, m.d2, m.f1, m.f2, m.ce, m.r, m.bsy, m.done});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [3:0] a5_d1 = 4'b0011;
    logic [3:0] a5_d2 = 4'b1100;
    logic [2:0] b_words_d1 = 3'b101;
    logic [2:0] b_words_d2 = 3'b110;
    logic [1:0] b_words [3] = '{2'b01, 2'b10, 2'b11};

    initial begin
        int busy_cnt;
        int ready_cnt;
        step();
        step();
        chk_en = 1'b1;
        step();
        chk("in_reset_r", {15'd0, oddr_r}, 16'd1);
        chk("in_reset_ce", {15'd0, oddr_ce}, 16'd0);

        // Reset release: R held for RST_CYCLES edges.
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("rst_hold_r", {15'd0, oddr_r}, (i < 4) ? 16'd1 : 16'd0);
        end
        chk("rst_done_ce", {15'd0, oddr_ce}, 16'd1);
        chk("rst_done_ready", {15'd0, s_ready}, 16'd1);

        // Single word 8'hA5; s_data changed after handshake must be ignored.
        s_valid = 1'b1;
        s_data = 8'hA5;
        step();
        s_valid = 1'b0;
        s_data = 8'hFF;
        for (int b = 0; b < 4; b++) begin
            chk("a5_d1", {15'd0, dq_d1}, {15'd0, a5_d1[b]});
            chk("a5_d2", {15'd0, dq_d2}, {15'd0, a5_d2[b]});
            chk("a5_fclk", {14'd0, fclk_d1, fclk_d2}, 16'd2);
            chk("a5_done", {15'd0, word_done}, (b == 3) ? 16'd1 : 16'd0);
            step();
        end
        chk("a5_idle", {13'd0, fclk_d1, busy, dq_d1}, 16'd0);

        // Back-to-back 01, FF, 80 with s_valid held.
        busy_cnt = 0;
        ready_cnt = 0;
        s_valid = 1'b1;
        s_data = 8'h01;
        for (int i = 0; i < 13; i++) begin
            step();
            if (i == 0) s_data = 8'hFF;
            if (i == 4) s_data = 8'h80;
            if (i == 8) s_valid = 1'b0;
            if (busy) busy_cnt++;
            if (busy && s_ready) ready_cnt++;
        end
        chk("b2b_busy_cycles", 16'(busy_cnt), 16'd12);
        chk("b2b_ready_cycles", 16'(ready_cnt), 16'd3);
        chk("b2b_end_idle", {15'd0, busy}, 16'd0);

        // enable dropped during 8'h3C: word finishes, nothing new accepted.
        s_valid = 1'b1;
        s_data = 8'h3C;
        step();
        step();
        enable = 1'b0;
        step();
        step();
        chk("en_last_done", {15'd0, word_done}, 16'd1);
        chk("en_last_ready", {15'd0, s_ready}, 16'd0);
        step();
        chk("en_idle_busy", {15'd0, busy}, 16'd0);
        chk("en_idle_ready", {15'd0, s_ready}, 16'd0);
        step();
        step();
        chk("en_still_blocked", {14'd0, s_ready, busy}, 16'd0);
        enable = 1'b1;
        s_valid = 1'b0;
        step();
        chk("en_restored", {15'd0, s_ready}, 16'd1);

        // Async reset mid-word.
        s_valid = 1'b1;
        s_data = 8'h96;
        step();
        s_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_outputs", {9'd0, dq_d1, dq_d2, oddr_r, oddr_ce, busy, s_ready, fclk_d1},
            16'h0010);
        chk("arst_b_dq", {14'd0, dq_d1_b, dq_d2_b}, 16'd3);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("rerst_hold_r", {15'd0, oddr_r}, (i < 4) ? 16'd1 : 16'd0);
        end

        // WIDTH=2, idle-high lane.
        chk("b_idle", {13'd0, dq_d1_b, dq_d2_b, s_ready_b}, 16'd7);
        s_valid_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data_b = b_words[i];
            step();
            chk("b_d1", {15'd0, dq_d1_b}, {15'd0, b_words_d1[i]});
            chk("b_d2", {15'd0, dq_d2_b}, {15'd0, b_words_d2[i]});
            chk("b_ready_done_fclk", {12'd0, s_ready_b, word_done_b, fclk_d1_b, fclk_d2_b},
                16'hE);
        end
        s_valid_b = 1'b0;
        step();
        chk("b_end_idle", {12'd0, dq_d1_b, dq_d2_b, busy_b, fclk_d1_b}, 16'hC);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
